// File: rtl/scan_shifter.sv
// Scan-tick generator and MSB-first serial driver for a chain of three 8-bit
// shift/latch registers feeding the multiplexed 7-segment/LED display.
module scan_shifter #(
  parameter int CLK_DIV     = 2,
  parameter int SCAN_PERIOD = 50000
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  output logic        o_TICK,
  input  logic [23:0] i_DATA,
  input  logic        i_VALID,
  output logic        o_SCLK,
  output logic        o_SDATA,
  output logic        o_LATCH,
  output logic        o_OE_N,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_OVERRUN,
  output logic [1:0]  o_DBG_STATE
);

  localparam int                SCAN_W    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
  localparam logic [7:0]        DIV_LAST  = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SHIFT_LO = 2'd1,
    S_SHIFT_HI = 2'd2,
    S_LATCH    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SCAN_W-1:0] r_scan;
  logic [7:0]        r_div;
  logic [4:0]        r_bit;
  logic [23:0]       r_shift;
  logic              r_done;
  logic              r_oe_n;
  logic              r_overrun;
  logic              w_half_end;
  logic              w_accept;
  logic              w_latch_end;

  // Handshake: a word is taken only on a cycle where i_VALID=1, the FSM is
  // IDLE and no frame ended on the previous edge; any other i_VALID is dropped
  // and flagged as overrun. There is no backpressure path to the decoder.
  always_comb begin
    w_next      = r_state;
    w_half_end  = (r_div == DIV_LAST);
    w_accept    = i_VALID && (r_state == S_IDLE) && !r_done;
    w_latch_end = (r_state == S_LATCH) && w_half_end;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = S_SHIFT_LO;
      S_SHIFT_LO: if (w_half_end) w_next = S_SHIFT_HI;
      S_SHIFT_HI: if (w_half_end) w_next = (r_bit == 5'd0) ? S_LATCH : S_SHIFT_LO;
      S_LATCH:    if (w_half_end) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state   <= S_IDLE;
      r_scan    <= '0;
      r_div     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
      r_oe_n    <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_scan  <= (r_scan == SCAN_LAST) ? '0 : r_scan + 1'b1;
      r_done  <= w_latch_end;
      if (w_latch_end) r_oe_n <= 1'b0;
      if (i_VALID && !w_accept) r_overrun <= 1'b1;

      if (r_state == S_IDLE || w_half_end) r_div <= '0;
      else                                 r_div <= r_div + 8'd1;

      if (w_accept) begin
        r_shift <= i_DATA;
        r_bit   <= 5'd23;
      end else if (r_state == S_SHIFT_HI && w_half_end && r_bit != 5'd0) begin
        r_shift <= {r_shift[22:0], 1'b0};
        r_bit   <= r_bit - 5'd1;
      end
    end
  end

  // Serial data is forced low outside the shift states so LATCH shows a clean line.
  assign o_SDATA     = (r_state == S_SHIFT_LO || r_state == S_SHIFT_HI) && r_shift[23];
  assign o_SCLK      = (r_state == S_SHIFT_HI);
  assign o_LATCH     = (r_state == S_LATCH);
  assign o_BUSY      = (r_state != S_IDLE);
  assign o_TICK      = (r_scan == SCAN_LAST);
  assign o_DONE      = r_done;
  assign o_OE_N      = r_oe_n;
  assign o_OVERRUN   = r_overrun;
  assign o_DBG_STATE = r_state;

endmodule

// File: tb/tb_scan_shifter.sv
// Directed bench for scan_shifter: two instances (CLK_DIV=2 and CLK_DIV=1),
// table of frames, mid-frame reset, tick cadence loop, overrun and done-cycle boundary.
module tb_scan_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, valid_a, rst_b, valid_b;
  logic [23:0] data_a, data_b;
  logic        tick_a, sclk_a, sdata_a, latch_a, oe_n_a, busy_a, done_a, ovr_a;
  logic        tick_b, sclk_b, sdata_b, latch_b, oe_n_b, busy_b, done_b, ovr_b;
  logic [1:0]  dbg_a, dbg_b;
  logic [7:0]  out_a, out_b;

  scan_shifter #(.CLK_DIV(2), .SCAN_PERIOD(200)) u_div2 (
    .i_CLK(clk), .i_RST(rst_a), .o_TICK(tick_a), .i_DATA(data_a), .i_VALID(valid_a),
    .o_SCLK(sclk_a), .o_SDATA(sdata_a), .o_LATCH(latch_a), .o_OE_N(oe_n_a),
    .o_BUSY(busy_a), .o_DONE(done_a), .o_OVERRUN(ovr_a), .o_DBG_STATE(dbg_a)
  );

  scan_shifter #(.CLK_DIV(1), .SCAN_PERIOD(200)) u_div1 (
    .i_CLK(clk), .i_RST(rst_b), .o_TICK(tick_b), .i_DATA(data_b), .i_VALID(valid_b),
    .o_SCLK(sclk_b), .o_SDATA(sdata_b), .o_LATCH(latch_b), .o_OE_N(oe_n_b),
    .o_BUSY(busy_b), .o_DONE(done_b), .o_OVERRUN(ovr_b), .o_DBG_STATE(dbg_b)
  );

  // Packed view: [7]tick [6]sclk [5]sdata [4]latch [3]oe_n [2]busy [1]done [0]overrun
  assign out_a = {tick_a, sclk_a, sdata_a, latch_a, oe_n_a, busy_a, done_a, ovr_a};
  assign out_b = {tick_b, sclk_b, sdata_b, latch_b, oe_n_b, busy_b, done_b, ovr_b};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs(input bit s);
    return s ? out_b : out_a;
  endfunction

  task automatic drive(input bit s, input logic v, input logic [23:0] d);
    if (s) begin valid_b = v; data_b = d; end
    else   begin valid_a = v; data_a = d; end
  endtask

  // Sends one word and monitors the frame on the selected instance.
  task automatic run_frame(input bit s, input logic [23:0] d, input int inj_at,
                           input logic [23:0] inj_d, input bit inj_done,
                           output logic [23:0] word, output int busy_n, output int latch_n,
                           output int done_idx, output int ones, output int rises,
                           output int unstable);
    logic [7:0] o, prev;
    word = '0; busy_n = 0; latch_n = 0; done_idx = -1; ones = 0; rises = 0; unstable = 0;
    @(negedge clk); drive(s, 1'b1, d);
    prev = outs(s);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk); drive(s, 1'b0, 24'h0);
      o = outs(s);
      if (o[2]) busy_n++;
      if (o[4]) latch_n++;
      if (o[2] && o[5]) ones++;
      if (!prev[6] && o[6]) begin
        rises++;
        word = {word[22:0], o[5]};
        if (o[5] !== prev[5]) unstable++;
      end
      if (i == inj_at) drive(s, 1'b1, inj_d);
      if (o[1]) begin
        done_idx = i;
        if (inj_done) drive(s, 1'b1, ~d);
        break;
      end
      prev = o;
    end
    @(negedge clk); drive(s, 1'b0, 24'h0);
  endtask

  typedef struct {
    bit          sel;
    logic [23:0] data;
    logic [23:0] exp_word;
    int          exp_busy;
    int          exp_latch;
    int          exp_ones;
  } vec_t;

  vec_t        tbl[5];
  logic [23:0] w;
  int          nb, nl, di, no, nr, nu;

  initial begin
    tbl[0] = '{0, 24'hA53C81, 24'hA53C81, 98, 2, 40};
    tbl[1] = '{0, 24'hFFFFFF, 24'hFFFFFF, 98, 2, 96};
    tbl[2] = '{1, 24'h000001, 24'h000001, 49, 1, 2};
    tbl[3] = '{1, 24'h800000, 24'h800000, 49, 1, 2};
    tbl[4] = '{1, 24'h5A5A5A, 24'h5A5A5A, 49, 1, 24};

    rst_a = 1'b1; rst_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    chk("reset_outs_a", out_a, 8'h08);
    chk("reset_outs_b", out_b, 8'h08);
    chk("reset_state_a", dbg_a, 2'd0);

    // Mid-frame reset aborts the frame without a latch or done
    begin
      int nlat, ndone, nbusy;
      @(negedge clk); drive(0, 1'b1, 24'hFFFFFF);
      @(negedge clk); drive(0, 1'b0, 24'h0);
      repeat (18) @(negedge clk);
      chk("midframe_busy", busy_a, 1'b1);
      rst_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("rst_hold_outs", out_a, 8'h08);
      end
      rst_a = 1'b0;
      nlat = 0; ndone = 0; nbusy = 0;
      for (int k = 0; k < 150; k++) begin
        @(negedge clk);
        nlat  += int'(latch_a);
        ndone += int'(done_a);
        nbusy += int'(busy_a);
      end
      chk("abort_no_latch", nlat, 0);
      chk("abort_no_done", ndone, 0);
      chk("abort_no_busy", nbusy, 0);
      chk("abort_oe_n", oe_n_a, 1'b1);
    end

    for (int t = 0; t < 5; t++) begin
      run_frame(tbl[t].sel, tbl[t].data, 0, 24'h0, 1'b0, w, nb, nl, di, no, nr, nu);
      chk("frame_word", w, tbl[t].exp_word);
      chk("frame_busy_len", nb, tbl[t].exp_busy);
      chk("frame_latch_len", nl, tbl[t].exp_latch);
      chk("frame_done_idx", di, tbl[t].exp_busy + 1);
      chk("frame_sdata_ones", no, tbl[t].exp_ones);
      chk("frame_sclk_rises", nr, 24);
      chk("frame_data_stable", nu, 0);
      chk("frame_oe_n", outs(tbl[t].sel) >> 3 & 8'h1, 8'h0);
      chk("frame_no_overrun", outs(tbl[t].sel) & 8'h1, 8'h0);
    end

    // Tick cadence with a decoder model answering each tick
    begin
      logic [7:0] o;
      int last, ticks, dones, pend;
      last = -1; ticks = 0; dones = 0; pend = -1;
      for (int c = 0; c < 1400 && !(ticks == 5 && dones == 5); c++) begin
        @(negedge clk); drive(0, 1'b0, 24'h0);
        o = out_a;
        if (pend == c) drive(0, 1'b1, 24'h00FF00 ^ 24'(ticks));
        if (o[7]) begin
          if (last >= 0) chk("tick_period", c - last, 200);
          last = c;
          ticks++;
          pend = c + 2;
        end
        if (o[1]) dones++;
      end
      chk("tick_count", ticks, 5);
      chk("tick_frames_done", dones, 5);
      chk("tick_no_overrun", ovr_a, 1'b0);
      @(negedge clk); drive(0, 1'b0, 24'h0);
    end

    // Overrun: second word 10 cycles into a frame is ignored
    run_frame(0, 24'h123456, 10, 24'hABCDEF, 1'b0, w, nb, nl, di, no, nr, nu);
    chk("ovr_word_kept", w, 24'h123456);
    chk("ovr_busy_len", nb, 98);
    chk("ovr_flag", ovr_a, 1'b1);
    run_frame(0, 24'h0F0F0F, 0, 24'h0, 1'b0, w, nb, nl, di, no, nr, nu);
    chk("ovr_next_word", w, 24'h0F0F0F);
    chk("ovr_sticky", ovr_a, 1'b1);

    // i_VALID on the o_DONE cycle is dropped
    chk("bnd_pre_overrun", ovr_b, 1'b0);
    run_frame(1, 24'hC3C3C3, 0, 24'h0, 1'b1, w, nb, nl, di, no, nr, nu);
    chk("bnd_word", w, 24'hC3C3C3);
    chk("bnd_done_idx", di, 50);
    chk("bnd_overrun", ovr_b, 1'b1);
    begin
      int nbusy;
      nbusy = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        nbusy += int'(busy_b);
      end
      chk("bnd_stays_idle", nbusy, 0);
      chk("bnd_state_idle", dbg_b, 2'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
